tdc_edge_sum_pipe: RTL

- Parametrised, pipelined edge encoder for the tapped-delay-line TDC.
- Takes one full thermometer snapshot per clock and finds the transition(s) at the selected polarity.
- Produces the weighted position sum and the edge count over the whole line, plus bubble/no-edge flags and a saturating hit counter.
- Sits between the delay-line capture registers and the fine-time/centroid calculation. Replaces the fixed 6-bit chunk summers with one configurable block.

---
 rtl/tdc_pkg.sv | 26 ++
 rtl/tdc_chunk_sum.sv | 48 ++++
 rtl/tdc_edge_sum_pipe.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/tdc_pkg.sv
// Shared constants, width helpers and result record for the delay-line edge encoder.
package tdc_pkg;

    localparam int DEF_TAPS  = 48;
    localparam int DEF_CHUNK = 6;

    // Width that holds 1+2+...+(taps-1), the all-edges position sum.
    function automatic int pos_width(input int taps);
        return $clog2(taps * (taps - 1) / 2 + 1);
    endfunction

    function automatic int cnt_width(input int taps);
        return $clog2(taps + 1);
    endfunction

    localparam int DEF_POS_W = pos_width(DEF_TAPS);
    localparam int DEF_CNT_W = cnt_width(DEF_TAPS);

    typedef struct packed {
        logic [DEF_POS_W-1:0] sum_position;
        logic [DEF_CNT_W-1:0] num_edge;
        logic                 no_edge;
        logic                 multi_edge;
    } tdc_result_t;

endpackage

// File: rtl/tdc_chunk_sum.sv
// One chunk of the edge vector: registered weighted position sum (1-based) and popcount.
module tdc_chunk_sum
    import tdc_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK,
    parameter int LS_W  = pos_width(CHUNK + 1),
    parameter int C_W   = cnt_width(CHUNK)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [CHUNK-1:0] e,
    output logic [LS_W-1:0]  local_sum,
    output logic [C_W-1:0]   cnt
);

    logic [LS_W-1:0] sum_d, sum_q;
    logic [C_W-1:0]  cnt_d, cnt_q;

    always_comb begin
        sum_d = sum_q;
        cnt_d = cnt_q;
        if (in_valid) begin
            sum_d = '0;
            cnt_d = '0;
            for (int j = 0; j < CHUNK; j++) begin
                if (e[j]) begin
                    sum_d = sum_d + LS_W'(j + 1);
                    cnt_d = cnt_d + C_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
            cnt_q <= '0;
        end else begin
            sum_q <= sum_d;
            cnt_q <= cnt_d;
        end
    end

    assign local_sum = sum_q;
    assign cnt       = cnt_q;

endmodule

// File: rtl/tdc_edge_sum_pipe.sv
// Four-stage edge encoder: capture, edge detect, per-chunk sums, combine + flags + hit counter.
module tdc_edge_sum_pipe
    import tdc_pkg::*;
#(
    parameter int TAPS  = DEF_TAPS,
    parameter int CHUNK = DEF_CHUNK,
    parameter int POS_W = pos_width(TAPS),
    parameter int CNT_W = cnt_width(TAPS),
    parameter int HIT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [TAPS-1:0]  therm,
    input  logic             polarity,
    input  logic             clr,
    output logic             out_valid,
    output logic [POS_W-1:0] sum_position,
    output logic [CNT_W-1:0] num_edge,
    output logic             no_edge,
    output logic             multi_edge,
    output logic [HIT_W-1:0] hit_cnt
);

    localparam int NCH  = TAPS / CHUNK;
    localparam int LS_W = pos_width(CHUNK + 1);
    localparam int LC_W = cnt_width(CHUNK);

    if (TAPS % CHUNK != 0) begin : g_bad_taps
        $error("TAPS must be a multiple of CHUNK");
    end
    if (CHUNK < 2 || CHUNK > 8) begin : g_bad_chunk
        $error("CHUNK must lie in 2..8");
    end

    logic            s1_valid_q, s2_valid_q, s3_valid_q;
    logic [TAPS-1:0] therm_d, therm_q;
    logic            pol_d, pol_q;
    logic [TAPS-1:0] evec_d, evec_q;
    logic [LS_W-1:0] lsum [NCH];
    logic [LC_W-1:0] lcnt [NCH];
    logic [POS_W-1:0] sum_d, sum_q;
    logic [CNT_W-1:0] num_d, num_q;
    logic            no_edge_d, no_edge_q, multi_d, multi_q, out_valid_q;
    logic [HIT_W-1:0] hit_d, hit_q;

    always_comb begin
        therm_d = in_valid ? therm : therm_q;
        pol_d   = in_valid ? polarity : pol_q;
    end

    // Top tap has no successor, so it never carries an edge.
    always_comb begin
        evec_d = evec_q;
        if (s1_valid_q) begin
            for (int i = 0; i < TAPS - 1; i++) begin
                evec_d[i] = pol_q ? (~therm_q[i] & therm_q[i+1])
                                  : (therm_q[i] & ~therm_q[i+1]);
            end
            evec_d[TAPS-1] = 1'b0;
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_chunk
        tdc_chunk_sum #(
            .CHUNK (CHUNK),
            .LS_W  (LS_W),
            .C_W   (LC_W)
        ) u_chunk (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (s2_valid_q),
            .e         (evec_q[gi*CHUNK +: CHUNK]),
            .local_sum (lsum[gi]),
            .cnt       (lcnt[gi])
        );
    end

    // Rebase each chunk's local positions by its starting tap.
    always_comb begin
        sum_d     = sum_q;
        num_d     = num_q;
        no_edge_d = no_edge_q;
        multi_d   = multi_q;
        if (s3_valid_q) begin
            sum_d = '0;
            num_d = '0;
            for (int k = 0; k < NCH; k++) begin
                sum_d = sum_d + POS_W'(lsum[k]) + POS_W'(k * CHUNK) * POS_W'(lcnt[k]);
                num_d = num_d + CNT_W'(lcnt[k]);
            end
            no_edge_d = (num_d == '0);
            multi_d   = (num_d > CNT_W'(1));
        end
    end

    always_comb begin
        hit_d = hit_q;
        if (clr)
            hit_d = '0;
        else if (s3_valid_q && num_d != '0 && hit_q != '1)
            hit_d = hit_q + HIT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s3_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            therm_q     <= '0;
            pol_q       <= 1'b0;
            evec_q      <= '0;
            sum_q       <= '0;
            num_q       <= '0;
            no_edge_q   <= 1'b0;
            multi_q     <= 1'b0;
            hit_q       <= '0;
        end else begin
            s1_valid_q  <= in_valid;
            s2_valid_q  <= s1_valid_q;
            s3_valid_q  <= s2_valid_q;
            out_valid_q <= s3_valid_q;
            therm_q     <= therm_d;
            pol_q       <= pol_d;
            evec_q      <= evec_d;
            sum_q       <= sum_d;
            num_q       <= num_d;
            no_edge_q   <= no_edge_d;
            multi_q     <= multi_d;
            hit_q       <= hit_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign sum_position = sum_q;
    assign num_edge     = num_q;
    assign no_edge      = no_edge_q;
    assign multi_edge   = multi_q;
    assign hit_cnt      = hit_q;

endmodule
